// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 set-2 keyboard receiver and key event decoder.
// Turns raw ps2_clk/ps2_data frames into ascii + press/back/enter strobes.
`timescale 1ns/1ps
module ps2_key_decoder #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] ascii,
    output logic       if_press,
    output logic       if_back,
    output logic       if_enter,
    output logic       frame_err
);
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

    logic [2:0]    ps2c_sync_q, ps2c_sync_d;
    logic [2:0]    ps2d_sync_q, ps2d_sync_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [9:0]    shreg_q, shreg_d;
    logic [IW-1:0] idle_q, idle_d;
    logic          code_valid_q, code_valid_d;
    logic [7:0]    code_q, code_d;
    logic          frame_err_q, frame_err_d;
    logic          shift_q, shift_d;
    logic          caps_q, caps_d;
    logic          brk_q, brk_d;
    logic          ext_q, ext_d;
    logic [7:0]    ascii_q, ascii_d;
    logic          press_q, press_d;
    logic          back_q, back_d;
    logic          enter_q, enter_d;

    logic          fall;
    logic          din;
    logic [7:0]    lower;
    logic [15:0]   dig;
    logic          is_shift;
    logic          map_hit;
    logic [7:0]    map_char;

    // Synchronize the PS/2 lines and shift in frame bits on falling edges
    always_comb begin
        ps2c_sync_d  = {ps2c_sync_q[1:0], ps2_clk};
        ps2d_sync_d  = {ps2d_sync_q[1:0], ps2_data};
        fall         = ps2c_sync_q[2] & ~ps2c_sync_q[1];
        din          = ps2d_sync_q[2];
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        idle_d       = idle_q;
        code_valid_d = 1'b0;
        code_d       = code_q;
        frame_err_d  = 1'b0;
        if (fall) begin
            idle_d = '0;
            if (bit_cnt_q == 4'd10) begin
                bit_cnt_d = 4'd0;
                // shreg: [0]=start, [8:1]=data, [9]=odd parity
                if (!shreg_q[0] && din && (^shreg_q[9:1])) begin
                    code_valid_d = 1'b1;
                    code_d       = shreg_q[8:1];
                end else begin
                    frame_err_d = 1'b1;
                end
            end else begin
                shreg_d   = {din, shreg_q[9:1]};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end else if (bit_cnt_q != 4'd0) begin
            if (idle_q == IW'(TIMEOUT_CYCLES)) begin
                bit_cnt_d = 4'd0;
                idle_d    = '0;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end
    end

    // Scan-code to character lookup; zero means "not in this table"
    always_comb begin
        case (code_q)
            8'h1C: lower = "a";
            8'h32: lower = "b";
            8'h21: lower = "c";
            8'h23: lower = "d";
            8'h24: lower = "e";
            8'h2B: lower = "f";
            8'h34: lower = "g";
            8'h33: lower = "h";
            8'h43: lower = "i";
            8'h3B: lower = "j";
            8'h42: lower = "k";
            8'h4B: lower = "l";
            8'h3A: lower = "m";
            8'h31: lower = "n";
            8'h44: lower = "o";
            8'h4D: lower = "p";
            8'h15: lower = "q";
            8'h2D: lower = "r";
            8'h1B: lower = "s";
            8'h2C: lower = "t";
            8'h3C: lower = "u";
            8'h2A: lower = "v";
            8'h1D: lower = "w";
            8'h22: lower = "x";
            8'h35: lower = "y";
            8'h1A: lower = "z";
            default: lower = 8'h00;
        endcase
        // {unshifted, shifted}
        case (code_q)
            8'h45: dig = {8'h30, 8'h29};
            8'h16: dig = {8'h31, 8'h21};
            8'h1E: dig = {8'h32, 8'h40};
            8'h26: dig = {8'h33, 8'h23};
            8'h25: dig = {8'h34, 8'h24};
            8'h2E: dig = {8'h35, 8'h25};
            8'h36: dig = {8'h36, 8'h5E};
            8'h3D: dig = {8'h37, 8'h26};
            8'h3E: dig = {8'h38, 8'h2A};
            8'h46: dig = {8'h39, 8'h28};
            default: dig = 16'h0000;
        endcase
        map_hit  = 1'b1;
        map_char = 8'h00;
        if (lower != 8'h00) begin
            map_char = (shift_q ^ caps_q) ? lower - 8'h20 : lower;
        end else if (dig != 16'h0000) begin
            map_char = shift_q ? dig[7:0] : dig[15:8];
        end else if (code_q == 8'h29) begin
            map_char = 8'h20;
        end else begin
            map_hit = 1'b0;
        end
        is_shift = (code_q == 8'h12) || (code_q == 8'h59);
    end

    // Track prefixes and modifiers and pick the event for each code
    always_comb begin
        shift_d = shift_q;
        caps_d  = caps_q;
        brk_d   = brk_q;
        ext_d   = ext_q;
        ascii_d = ascii_q;
        press_d = 1'b0;
        back_d  = 1'b0;
        enter_d = 1'b0;
        if (code_valid_q) begin
            if (code_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (code_q == 8'hF0) begin
                brk_d = 1'b1;
            end else if (brk_q) begin
                if (is_shift) shift_d = 1'b0;
                brk_d = 1'b0;
                ext_d = 1'b0;
            end else begin
                ext_d = 1'b0;
                if (is_shift) begin
                    shift_d = 1'b1;
                end else if (code_q == 8'h58) begin
                    caps_d = ~caps_q;
                end else if (code_q == 8'h5A) begin
                    enter_d = 1'b1;
                end else if (code_q == 8'h66 && !ext_q) begin
                    back_d = 1'b1;
                end else if (!ext_q && map_hit) begin
                    press_d = 1'b1;
                    ascii_d = map_char;
                end
            end
        end
    end

    // All state; reset returns lines to idle-high and clears modifiers
    always_ff @(posedge clk) begin
        if (reset) begin
            ps2c_sync_q  <= 3'b111;
            ps2d_sync_q  <= 3'b111;
            bit_cnt_q    <= 4'd0;
            shreg_q      <= 10'd0;
            idle_q       <= '0;
            code_valid_q <= 1'b0;
            code_q       <= 8'h00;
            frame_err_q  <= 1'b0;
            shift_q      <= 1'b0;
            caps_q       <= 1'b0;
            brk_q        <= 1'b0;
            ext_q        <= 1'b0;
            ascii_q      <= 8'h00;
            press_q      <= 1'b0;
            back_q       <= 1'b0;
            enter_q      <= 1'b0;
        end else begin
            ps2c_sync_q  <= ps2c_sync_d;
            ps2d_sync_q  <= ps2d_sync_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            idle_q       <= idle_d;
            code_valid_q <= code_valid_d;
            code_q       <= code_d;
            frame_err_q  <= frame_err_d;
            shift_q      <= shift_d;
            caps_q       <= caps_d;
            brk_q        <= brk_d;
            ext_q        <= ext_d;
            ascii_q      <= ascii_d;
            press_q      <= press_d;
            back_q       <= back_d;
            enter_q      <= enter_d;
        end
    end

    assign ascii     = ascii_q;
    assign if_press  = press_q;
    assign if_back   = back_q;
    assign if_enter  = enter_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: scoreboard bench for ps2_key_decoder.
// A keyboard-level model predicts events; a monitor checks the DUT strobes.
`timescale 1ns/1ps
module tb_ps2_key_decoder;
    localparam int TO   = 200;
    localparam int HALF = 8;
    localparam int K_PRESS = 0;
    localparam int K_BACK  = 1;
    localparam int K_ENTER = 2;
    localparam int K_ERR   = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] ascii;
    logic       if_press, if_back, if_enter, frame_err;

    ps2_key_decoder #(.TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .ascii     (ascii),
        .if_press  (if_press),
        .if_back   (if_back),
        .if_enter  (if_enter),
        .frame_err (frame_err)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         kind;
        logic [7:0] asc;
        int         at;
    } ev_t;
    ev_t expq[$];

    int errors = 0;
    int checks = 0;

    // keyboard-level reference state
    bit         m_shift, m_caps, m_brk, m_ext;
    logic [7:0] m_ascii;

    logic [7:0] letter_codes[26] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
        8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
        8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digit_codes[10] = '{
        8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E,
        8'h46};
    string dsym = ")!@#$%^&*(";
    logic [7:0] pool[24] = '{
        8'h1C, 8'h32, 8'h15, 8'h1A, 8'h44, 8'h2D, 8'h45, 8'h16, 8'h1E,
        8'h36, 8'h46, 8'h12, 8'h59, 8'h12, 8'h58, 8'h5A, 8'h66, 8'h29,
        8'h75, 8'h07, 8'h0D, 8'h12, 8'h3E, 8'h59};

    function automatic bit lookup(input logic [7:0] c,
                                  output logic [7:0] ch);
        ch = 8'h00;
        for (int i = 0; i < 26; i++)
            if (letter_codes[i] == c) begin
                ch = ((m_shift ^ m_caps) ? 8'h41 : 8'h61) + 8'(i);
                return 1'b1;
            end
        for (int i = 0; i < 10; i++)
            if (digit_codes[i] == c) begin
                ch = m_shift ? 8'(dsym[i]) : 8'h30 + 8'(i);
                return 1'b1;
            end
        if (c == 8'h29) begin
            ch = 8'h20;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic void push_ev(input int kind, input int at);
        ev_t e;
        e.kind = kind;
        e.asc  = m_ascii;
        e.at   = at;
        expq.push_back(e);
    endfunction

    // at = cycle number when the stop-bit falling edge was driven
    function automatic void model_byte(input logic [7:0] c, input int at);
        logic [7:0] ch;
        if (c == 8'hE0) m_ext = 1'b1;
        else if (c == 8'hF0) m_brk = 1'b1;
        else if (m_brk) begin
            if (c == 8'h12 || c == 8'h59) m_shift = 1'b0;
            m_brk = 1'b0;
            m_ext = 1'b0;
        end else begin
            if (c == 8'h12 || c == 8'h59) m_shift = 1'b1;
            else if (c == 8'h58) m_caps = ~m_caps;
            else if (c == 8'h5A) push_ev(K_ENTER, at + 4);
            else if (c == 8'h66 && !m_ext) push_ev(K_BACK, at + 4);
            else if (!m_ext && lookup(c, ch)) begin
                m_ascii = ch;
                push_ev(K_PRESS, at + 4);
            end
            m_ext = 1'b0;
        end
    endfunction

    task automatic send_frame(input logic [7:0] code, input bit bad_par,
                              input bit bad_stop, input int nbits);
        logic [10:0] f;
        f = {~bad_stop, (~^code) ^ bad_par, code, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2_data = f[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            if (i == 10) begin
                if (bad_par || bad_stop) push_ev(K_ERR, cyc + 3);
                else model_byte(code, cyc);
            end
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        @(negedge clk);
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic key(input logic [7:0] code);
        send_frame(code, 1'b0, 1'b0, 11);
    endtask

    task automatic do_reset();
        @(negedge clk);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL pending_before_reset: %0d events still expected, required 0",
                     expq.size());
            expq.delete();
        end
        reset = 1'b1;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (ascii !== 8'h00 || if_press !== 1'b0 || if_back !== 1'b0 ||
            if_enter !== 1'b0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ascii=%h press=%b back=%b enter=%b err=%b, required all 0",
                     ascii, if_press, if_back, if_enter, frame_err);
        end
        m_shift = 1'b0;
        m_caps  = 1'b0;
        m_brk   = 1'b0;
        m_ext   = 1'b0;
        m_ascii = 8'h00;
        reset = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // monitor: every strobe cycle must match the head of the scoreboard
    initial begin
        ev_t e;
        int  k;
        int  n;
        forever begin
            @(negedge clk);
            if (!reset && (if_press | if_back | if_enter | frame_err)) begin
                n = int'(if_press) + int'(if_back) + int'(if_enter) +
                    int'(frame_err);
                k = frame_err ? K_ERR : if_enter ? K_ENTER :
                    if_back ? K_BACK : K_PRESS;
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: kind=%0d ascii=%h at cycle %0d, required none",
                             k, ascii, cyc);
                end else begin
                    e = expq.pop_front();
                    if (n != 1 || k != e.kind || cyc != e.at ||
                        ascii !== e.asc) begin
                        errors++;
                        $display("FAIL event: got kind=%0d strobes=%0d ascii=%h cycle=%0d, required kind=%0d strobes=1 ascii=%h cycle=%0d",
                                 k, n, ascii, cyc, e.kind, e.asc, e.at);
                    end
                end
            end
        end
    end

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        logic [7:0] c;
        do_reset();

        // single letter
        key(8'h1C);
        // shift make/break around letters
        key(8'h12); key(8'h1C); key(8'hF0); key(8'h1C);
        key(8'hF0); key(8'h12); key(8'h1C);
        // caps does not affect digits; shift does
        key(8'h58); key(8'hF0); key(8'h58); key(8'h16);
        key(8'h12); key(8'h16);
        key(8'hF0); key(8'h12); key(8'h58); key(8'h15);
        // typematic repeats
        key(8'h15); key(8'h15);
        // backspace, enter, extended enter, arrow
        key(8'h66); key(8'h5A);
        key(8'hE0); key(8'h5A);
        key(8'hE0); key(8'h75);
        key(8'hE0); key(8'h66);
        // bad parity, bad stop
        send_frame(8'h1C, 1'b1, 1'b0, 11);
        send_frame(8'h1C, 1'b0, 1'b1, 11);
        // partial frame then timeout then space
        send_frame(8'h00, 1'b0, 1'b0, 5);
        repeat (TO + 30) @(negedge clk);
        key(8'h29);
        // caps on, reset mid-frame, letter must be lowercase
        key(8'h58);
        send_frame(8'h1C, 1'b0, 1'b0, 6);
        do_reset();
        key(8'h1C);

        // randomized traffic
        for (int n = 0; n < 55; n++) begin
            r = $urandom_range(0, 99);
            c = pool[$urandom_range(0, 23)];
            if (r < 8) send_frame(c, 1'b1, 1'b0, 11);
            else if (r < 12) send_frame(c, 1'b0, 1'b1, 11);
            else if (r < 30) begin key(8'hF0); key(c); end
            else if (r < 38) begin key(8'hE0); key(c); end
            else key(c);
        end

        repeat (30) @(negedge clk);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL missing_events: %0d expected events never seen, required 0",
                     expq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Receives PS/2 set-2 keyboard frames on the raw `ps2_clk`/`ps2_data` lines and converts them into the terminal's key event interface. It outputs `ascii` plus one-cycle `if_press`, `if_back` and `if_enter` strobes, and feeds the VGA text terminal top directly. It runs in the 50 MHz system clock domain. It oversamples the PS/2 lines, tracks the Shift, Caps Lock, break (F0) and extended (E0) prefixes, and emits exactly one event per key make code, including typematic repeats.

## Interface
- `TIMEOUT_CYCLES`, default 50000: number of `clk` cycles without a PS/2 falling edge, mid-frame, after which the partial frame is discarded (1 ms at 50 MHz).
- `clk`  input  1  system clock, 50 MHz.
- `reset`  input  1  synchronous reset, active-high.
- `ps2_clk`  input  1  raw PS/2 clock; asynchronous.
- `ps2_data`  input  1  raw PS/2 data; asynchronous.
- `ascii`  output  8  ASCII code of the last printable key. Updated only together with `if_press` and held between presses.
- `if_press`  output  1  one-cycle pulse: printable key made.
- `if_back`  output  1  one-cycle pulse: Backspace (0x66) made.
- `if_enter`  output  1  one-cycle pulse: Enter (0x5A or E0 5A) made.
- `frame_err`  output  1  one-cycle pulse: a frame was rejected.

## Operation
- **Synchronizer:** `ps2_clk` and `ps2_data` each pass through a 3-flop synchronizer. A falling edge is detected when the older sync stage is 1 and the newer is 0. `ps2_data` is sampled from its synchronized stage in the same cycle.
- **Frame receiver:** 11 bits, LSB first: start(0), d0..d7, odd parity, stop(1). A 4-bit counter runs 0..10 and advances on each falling edge. On bit 10 the frame is checked: start==0, stop==1, and XOR of (d0..d7, parity)==1.
  - Frame valid: `code_valid` pulses for one cycle with the 8-bit `code`.
  - Frame invalid: `frame_err` pulses and the frame is dropped.
  - Either way, the counter returns to 0.
- **Timeout:** an idle counter clears on every falling edge. If bit count ≠ 0 and the idle count reaches `TIMEOUT_CYCLES`, the bit count returns to 0. No `frame_err` is raised for a timeout.
- **Prefix and modifier state**, evaluated per `code_valid`:
  - 0xE0: set `ext`. 0xF0: set `brk`. Neither byte emits an event.
  - Any other code with `brk`=1: if the code is 0x12 or 0x59, clear `shift`. Then clear both `brk` and `ext`. No event.
  - Any other code with `brk`=0:
    - 0x12/0x59: set `shift`.
    - 0x58: toggle `caps`.
    - 0x5A: `if_enter` (with or without `ext`).
    - 0x66 (no `ext`): `if_back`.
    - Else, if `ext`=0 and the code is mapped: `if_press` with `ascii`.
    - Clear `ext` afterward.
- **Mapping, letters:** A1C B32 C21 D23 E24 F2B G34 H33 I43 J3B K42 L4B M3A N31 O44 P4D Q15 R2D S1B T2C U3C V2A W1D X22 Y35 Z1A.
  - Uppercase (0x41–0x5A) when `shift` XOR `caps` is 1; lowercase (0x61–0x7A) otherwise.
- **Mapping, digits:** 0:45 1:16 2:1E 3:26 4:25 5:2E 6:36 7:3D 8:3E 9:46.
  - Unshifted: 0x30–0x39.
  - Shifted: `) ! @ # $ % ^ & * (` respectively. `caps` has no effect on digits.
- **Mapping, other:** Space 0x29 → 0x20.
- **Unmapped codes:** produce no strobe and leave `ascii` unchanged.
- **Strobes:** at most one of `if_press`/`if_back`/`if_enter` is high in any cycle.

## Timing
- **Latency:** the stop-bit falling edge is detected at cycle t. `code_valid`/`frame_err` assert at t+1. The event strobe and updated `ascii` assert at t+2. All strobes are exactly 1 cycle wide.
- **Reset values:** `ascii`=0x00; `if_press`, `if_back`, `if_enter`, `frame_err`=0; `shift`, `caps`, `brk`, `ext`=0; bit and idle counters 0; sync flops 1 (idle line).
- **Reset priority:** reset overrides everything. Reset mid-frame discards the partial frame and all modifier state, including `caps`.
- **Repeats:** typematic repeats (the same make code again with no break) produce one event per repeat.
- **Falling-edge spacing:** PS/2 falling edges are ≥30 µs apart. The receiver requires no handshake and never back-pressures.

## Test plan
- Frame 0x1C (start 0, data LSB-first, parity 0, stop 1) → `if_press` 1 cycle, `ascii`=0x61 at t+2.
- Sequence 12, 1C, F0 1C, F0 12, 1C → `ascii` 0x41 then 0x61. Exactly 2 press pulses; none on the break bytes.
- Sequence 58, F0 58, 16, 12, 16 → `ascii` 0x31, then 0x21. With 0x58 repeated, letter 0x15 gives 0x71.
- Sequence 66 → `if_back` only. E0 5A → `if_enter` only. E0 75 (arrow) → no strobe and `ascii` unchanged.
- Frame 0x1C with wrong parity → `frame_err` pulse, no `if_press`. A 5-bit partial frame, then idle for `TIMEOUT_CYCLES`, then a valid 0x29 frame → `ascii`=0x20.
- `reset` asserted at bit 6 of a frame, then a full 0x1C frame → `ascii`=0x61, regardless of prior `caps`.
